demux_sel_sequencer: RTL and testbench

- Upstream feeder for the 1:4 demux (`demux1_beh` / `demux1_dat`). Drives its data input `I` and select `s`.
- Accepts single-bit beats on a valid/ready handshake and picks a target lane, either round-robin over enabled lanes or from an explicit address.
- Holds each beat until the downstream lane reports ready, then drives it onto the demux for a fixed number of cycles.

---
 rtl/demux_sel_sequencer.sv | 154 +++++++++++++++
 tb/tb_demux_sel_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_sel_sequencer.sv
// Upstream feeder for the 1:4 demux: accepts single-bit beats, picks a lane (round-robin or explicit), drives I/s.
// Optional macro SEQ_TIMEOUT_EN: drop a beat whose lane stays not-ready for 16 consecutive WAIT cycles.
module demux_sel_sequencer #(
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned HOLD_CYC = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_bit,
    input  logic [SEL_W-1:0]          in_addr,
    input  logic                      addr_mode,
    input  logic [(1<<SEL_W)-1:0]     lane_mask,
    input  logic [(1<<SEL_W)-1:0]     lane_ready,
    output logic                      dmx_i,
    output logic [SEL_W-1:0]          dmx_s,
    output logic                      dmx_stb,
    output logic                      busy,
    output logic                      err_drop,
    output logic [7:0]                beat_cnt
);
    localparam int unsigned NLANE     = 1 << SEL_W;
    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_WAIT    = 2'd1;
    localparam logic [1:0]  S_DRIVE   = 2'd2;
    localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYC - 1);

    logic [1:0]       state, state_d;
    logic [SEL_W-1:0] target, target_d;
    logic [SEL_W-1:0] rr_ptr, rr_ptr_d;
    logic             bit_q, bit_d;
    logic             mode_q, mode_d;
    logic [3:0]       hold_cnt, hold_cnt_d;
    logic [7:0]       beat_cnt_d;
    logic             err_d;
    logic             rr_found;
    logic [SEL_W-1:0] rr_pick;
    logic [SEL_W-1:0] idx;
`ifdef SEQ_TIMEOUT_EN
    logic [3:0]       to_cnt, to_cnt_d;
`endif

    // First enabled lane at or after rr_ptr; descending scan so the smallest offset wins.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = rr_ptr;
        idx      = rr_ptr;
        for (int i = NLANE - 1; i >= 0; i--) begin
            idx = rr_ptr + SEL_W'(i);
            if (lane_mask[idx]) begin
                rr_found = 1'b1;
                rr_pick  = idx;
            end
        end
    end

    always_comb begin
        state_d    = state;
        target_d   = target;
        rr_ptr_d   = rr_ptr;
        bit_d      = bit_q;
        mode_d     = mode_q;
        hold_cnt_d = hold_cnt;
        beat_cnt_d = beat_cnt;
        err_d      = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        to_cnt_d   = to_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    if (addr_mode ? lane_mask[in_addr] : rr_found) begin
                        state_d  = S_WAIT;
                        target_d = addr_mode ? in_addr : rr_pick;
                        bit_d    = in_bit;
                        mode_d   = addr_mode;
`ifdef SEQ_TIMEOUT_EN
                        to_cnt_d = 4'd0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (lane_ready[target]) begin
                    state_d    = S_DRIVE;
                    hold_cnt_d = 4'd0;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (to_cnt == 4'hF) begin
                    // Dead lane: discard, and let round-robin move past it.
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    if (!mode_q) rr_ptr_d = target + SEL_W'(1);
                end else begin
                    to_cnt_d = to_cnt + 4'd1;
                end
`endif
            end
            S_DRIVE: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_d    = S_IDLE;
                    beat_cnt_d = (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;
                    if (!mode_q) rr_ptr_d = target + SEL_W'(1);
                end else begin
                    hold_cnt_d = hold_cnt + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            target   <= '0;
            rr_ptr   <= '0;
            bit_q    <= 1'b0;
            mode_q   <= 1'b0;
            hold_cnt <= 4'd0;
            beat_cnt <= 8'd0;
            err_drop <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            dmx_i    <= 1'b0;
            dmx_s    <= '0;
            dmx_stb  <= 1'b0;
        end else begin
            state    <= state_d;
            target   <= target_d;
            rr_ptr   <= rr_ptr_d;
            bit_q    <= bit_d;
            mode_q   <= mode_d;
            hold_cnt <= hold_cnt_d;
            beat_cnt <= beat_cnt_d;
            err_drop <= err_d;
            in_ready <= (state_d == S_IDLE) && (addr_mode || (|lane_mask));
            busy     <= (state_d != S_IDLE);
            dmx_i    <= (state_d == S_DRIVE) && bit_d;
            dmx_s    <= (state_d != S_IDLE) ? target_d : dmx_s;
            dmx_stb  <= (state_d == S_DRIVE);
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) to_cnt <= 4'd0;
        else     to_cnt <= to_cnt_d;
    end
`endif

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Self-checking bench for demux_sel_sequencer: directed and randomized beats against a transaction-level model.
`timescale 1ns/1ps
module tb_demux_sel_sequencer;
    localparam int unsigned HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_bit, addr_mode;
    logic [1:0] in_addr;
    logic [3:0] lane_mask, lane_ready;
    logic       dmx_i, dmx_stb, busy, err_drop;
    logic [1:0] dmx_s;
    logic [7:0] beat_cnt;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_rr  = 2'd0;
    int         exp_cnt = 0;

    demux_sel_sequencer #(.SEL_W(2), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
        .in_addr(in_addr), .addr_mode(addr_mode), .lane_mask(lane_mask), .lane_ready(lane_ready),
        .dmx_i(dmx_i), .dmx_s(dmx_s), .dmx_stb(dmx_stb), .busy(busy), .err_drop(err_drop),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first enabled lane scanning from the pointer, modulo 4.
    function automatic logic [1:0] rr_target(input logic [1:0] p, input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (int'(p) + i) % 4;
            if (m[k]) return 2'(k);
        end
        return p;
    endfunction

    task automatic accept_beat(input logic b, input logic mode, input logic [1:0] addr,
                               input logic [3:0] mask, input int stall,
                               output logic dropped, output logic [1:0] lane);
        @(negedge clk);
        in_bit = b; addr_mode = mode; in_addr = addr; lane_mask = mask;
        lane_ready = (stall > 0) ? 4'h0 : 4'hF;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        dropped = mode && !mask[addr];
        lane = mode ? addr : rr_target(exp_rr, mask);
        if (dropped) begin
            chk("drop_err", 32'(err_drop), 32'd1);
            chk("drop_stb", 32'(dmx_stb), 32'd0);
            chk("drop_busy", 32'(busy), 32'd0);
            @(negedge clk);
            chk("drop_err_pulse", 32'(err_drop), 32'd0);
            chk("drop_cnt", 32'(beat_cnt), 32'(exp_cnt));
        end else begin
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_in_ready", 32'(in_ready), 32'd0);
            chk("wait_stb", 32'(dmx_stb), 32'd0);
            chk("wait_sel", 32'(dmx_s), 32'(lane));
            chk("wait_err", 32'(err_drop), 32'd0);
        end
    endtask

    task automatic finish_beat(input logic b, input logic mode, input logic [1:0] lane, input int stall);
        logic timed_out;
        timed_out = 1'b0;
        for (int k = 1; k <= stall; k++) begin
            @(negedge clk);
`ifdef SEQ_TIMEOUT_EN
            if (k == 16) begin
                chk("to_err", 32'(err_drop), 32'd1);
                chk("to_busy", 32'(busy), 32'd0);
                chk("to_stb", 32'(dmx_stb), 32'd0);
                chk("to_cnt", 32'(beat_cnt), 32'(exp_cnt));
                if (!mode) exp_rr = lane + 2'd1;
                timed_out = 1'b1;
                break;
            end
`endif
            chk("stall_stb", 32'(dmx_stb), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        if (timed_out) begin
            @(negedge clk);
            chk("to_err_pulse", 32'(err_drop), 32'd0);
        end else begin
            lane_ready = 4'b0001 << lane;
            for (int j = 0; j < int'(HOLD); j++) begin
                @(negedge clk);
                chk("drv_stb", 32'(dmx_stb), 32'd1);
                chk("drv_i", 32'(dmx_i), 32'(b));
                chk("drv_sel", 32'(dmx_s), 32'(lane));
                chk("drv_err", 32'(err_drop), 32'd0);
            end
            @(negedge clk);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            if (!mode) exp_rr = lane + 2'd1;
            chk("end_stb", 32'(dmx_stb), 32'd0);
            chk("end_i", 32'(dmx_i), 32'd0);
            chk("end_sel_hold", 32'(dmx_s), 32'(lane));
            chk("end_busy", 32'(busy), 32'd0);
            chk("end_in_ready", 32'(in_ready), 32'd1);
            chk("beat_cnt", 32'(beat_cnt), 32'(exp_cnt));
        end
    endtask

    task automatic send_beat(input logic b, input logic mode, input logic [1:0] addr,
                             input logic [3:0] mask, input int stall);
        logic       dropped;
        logic [1:0] lane;
        accept_beat(b, mode, addr, mask, stall, dropped, lane);
        if (!dropped) finish_beat(b, mode, lane, stall);
    endtask

    initial begin
        logic       dropped;
        logic [1:0] lane;
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; addr_mode = 1'b0;
        in_addr = 2'd0; lane_mask = 4'hF; lane_ready = 4'hF;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stb", 32'(dmx_stb), 32'd0);
        chk("rst_i", 32'(dmx_i), 32'd0);
        chk("rst_sel", 32'(dmx_s), 32'd0);
        chk("rst_err", 32'(err_drop), 32'd0);
        chk("rst_cnt", 32'(beat_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Round-robin, all lanes: 0,1,2,3
        for (int n = 0; n < 4; n++) send_beat(1'b1, 1'b0, 2'd0, 4'hF, 0);

        // Masked round-robin: only lanes 0 and 2
        for (int n = 0; n < 6; n++) send_beat(1'($urandom_range(1)), 1'b0, 2'd0, 4'b0101, 0);

        // Address mode: masked address dropped, then legal address delivered
        send_beat(1'b1, 1'b1, 2'b10, 4'b1011, 0);
        send_beat(1'b1, 1'b1, 2'b01, 4'b1011, 0);

        // Backpressure for 10 cycles
        send_beat(1'b1, 1'b0, 2'd0, 4'hF, 10);
`ifdef SEQ_TIMEOUT_EN
        send_beat(1'b1, 1'b0, 2'd0, 4'hF, 20);
        send_beat(1'b0, 1'b0, 2'd0, 4'hF, 0);
`endif

        // Randomized beats; mask/mode scrambled during WAIT must not move the target
        for (int n = 0; n < 40; n++) begin
            logic       b, m;
            logic [1:0] a;
            logic [3:0] mk;
            int         st;
            b  = 1'($urandom_range(1));
            m  = 1'($urandom_range(1));
            a  = 2'($urandom_range(3));
            mk = 4'($urandom_range(15, 1));
            st = int'($urandom_range(3));
            accept_beat(b, m, a, mk, st, dropped, lane);
            if (!dropped) begin
                lane_mask = 4'($urandom_range(15, 1));
                addr_mode = 1'($urandom_range(1));
                finish_beat(b, m, lane, st);
            end
        end

        // Reset during the 2nd DRIVE cycle aborts the beat
        accept_beat(1'b1, 1'b0, 2'd0, 4'hF, 0, dropped, lane);
        @(negedge clk);
        chk("abort_drv1", 32'(dmx_stb), 32'd1);
        @(negedge clk);
        chk("abort_drv2", 32'(dmx_stb), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        exp_rr  = 2'd0;
        chk("abort_stb", 32'(dmx_stb), 32'd0);
        chk("abort_i", 32'(dmx_i), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cnt", 32'(beat_cnt), 32'd0);
        // Pointer back at lane 0
        send_beat(1'b1, 1'b0, 2'd0, 4'hF, 0);

        // Saturation
        for (int n = 0; n < 259; n++) send_beat(1'($urandom_range(1)), 1'b0, 2'd0, 4'hF, 0);
        chk("sat_cnt", 32'(beat_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
